uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter between NUM_REQ byte requesters.
- Round-robin arbitration selects one requester and latches its byte.
- Issues a single-cycle tx_start to uart_tx, then tracks tx_busy until the frame completes.
- Sits between the per-source byte producers and the uart_tx instance.

---
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx transmitter between NUM_REQ byte requesters.
//            A round-robin arbiter picks one pending requester, latches its
//            byte, issues a one-cycle tx_start and then follows tx_busy until
//            the frame is finished. If tx_busy never rises after the start,
//            the grant is abandoned and a sticky timeout flag is raised.
//
// Build option:
//            UART_TX_ARB_FIXED_PRIO_EN - when defined, the lowest set req
//            index always wins and the round-robin pointer has no effect.
//
// Ports    : clk          in   system clock, rising edge
//            reset        in   asynchronous active-high reset
//            req          in   [NUM_REQ]   per-requester byte pending
//            req_data     in   [8*NUM_REQ] byte i on bits [8*i+7:8*i]
//            ack          out  [NUM_REQ]   one-hot pulse, byte accepted
//            grant_id     out  [ID_W]      current/last granted requester
//            tx_start     out  one-cycle start pulse to uart_tx
//            tx_data      out  [8]         latched byte to uart_tx
//            tx_busy      in   busy flag from uart_tx
//            arb_busy     out  high whenever the arbiter is not idle
//            timeout_err  out  sticky, tx_busy failed to rise in time
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter  int NUM_REQ       = 4,
   parameter  int BUSY_WAIT_MAX = 8,
   localparam int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [ID_W-1:0]      grant_id,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 arb_busy,
   output logic                 timeout_err
);

   localparam int              c_cnt_w    = $clog2(BUSY_WAIT_MAX + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BUSY_WAIT_MAX - 1);
   localparam logic [ID_W-1:0] c_ptr_rst  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [ID_W-1:0]      grant_id_q, grant_id_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 arb_busy_q, arb_busy_d;
   logic                 timeout_err_q, timeout_err_d;

   logic                 w_win_valid;
   logic [ID_W-1:0]      w_win_id;
   logic [7:0]           w_win_byte;

   // Winner selection
   always_comb begin
      w_win_valid = 1'b0;
      w_win_id    = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest set index is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_win_valid = 1'b1;
            w_win_id    = ID_W'(i);
         end
      end
`else
      begin : b_rr_search
         int              idx;
         logic [ID_W-1:0] idx_w;
         // Start one past the last winner; the wrap is an explicit
         // subtraction so non-power-of-two NUM_REQ never indexes past the end.
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = ID_W'(idx);
            if (!w_win_valid && req[idx_w]) begin
               w_win_valid = 1'b1;
               w_win_id    = idx_w;
            end
         end
      end
`endif
   end

   always_comb begin
      w_win_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_id == ID_W'(i)) w_win_byte = req_data[8*i +: 8];
      end
   end

   // Next-state logic; all outputs are registered so they line up with
   // the state they belong to (tx_start/ack are high exactly in START).
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      ack_d         = '0;
      grant_id_d    = grant_id_q;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (w_win_valid && !tx_busy) begin
               state_d    = S_START;
               ptr_d      = w_win_id;
               grant_id_d = w_win_id;
               tx_data_d  = w_win_byte;
               tx_start_d = 1'b1;
               ack_d      = NUM_REQ'(1) << w_win_id;
            end
         end
         S_START: begin
            state_d = S_WAIT_BUSY;
            cnt_d   = '0;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == c_cnt_last) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      arb_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= c_ptr_rst;
         cnt_q         <= '0;
         ack_q         <= '0;
         grant_id_q    <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= 8'h00;
         arb_busy_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         ack_q         <= ack_d;
         grant_id_q    <= grant_id_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         arb_busy_q    <= arb_busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_id_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign arb_busy    = arb_busy_q;
   assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//            BUSY_WAIT_MAX=8). Expected grants are queued when a request is
//            driven and checked when tx_start appears. Outputs are sampled on
//            the falling edge; inputs change right after that sample.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int BUSY_WAIT_MAX = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic [1:0]           grant_id;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic                 arb_busy;
   logic                 timeout_err;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .BUSY_WAIT_MAX (BUSY_WAIT_MAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .grant_id    (grant_id),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .arb_busy    (arb_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [7:0] data;
      logic [1:0] exp_id;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      sb.push_back(e);
   endtask

   // Called in the START cycle: compares the grant against the queue head.
   task automatic check_grant();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL sb_underflow: got tx_start id %0d expected none", grant_id);
      end else begin
         e = sb.pop_front();
         chk("grant_id", 32'(grant_id), 32'(e.id));
         chk("tx_data",  32'(tx_data),  32'(e.data));
         chk("ack",      32'(ack),      32'(4'b0001 << e.id));
      end
   endtask

   // uart_tx model: busy for busy_len cycles after each tx_start.
   task automatic run_frames(input int n_starts, input int busy_len,
                             input bit drop_on_ack, input int budget);
      int seen = 0;
      int rem  = 0;
      int cyc  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_start) begin
            check_grant();
            seen++;
            rem = busy_len;
            if (drop_on_ack) req = '0;
         end
         tx_busy = (rem > 0);
         if (rem > 0) rem--;
         if (seen >= n_starts && !arb_busy && !tx_busy) break;
         if (cyc >= budget) begin
            n_total++;
            $display("FAIL run_frames_budget: got %0d starts expected %0d", seen, n_starts);
            break;
         end
      end
      req = '0;
      chk("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      tx_busy  = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drive_one(input logic [3:0] r, input int slot, input logic [7:0] d);
      logic [31:0] rd;
      rd = $urandom;
      rd[8*slot +: 8] = d;
      req_data = rd;
      req      = r;
   endtask

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;

      vecs[0] = '{4'b0001, 8'h11, 2'd0};
      vecs[1] = '{4'b0010, 8'h22, 2'd1};
      vecs[2] = '{4'b0100, 8'hC3, 2'd2};
      vecs[3] = '{4'b1000, 8'h7E, 2'd3};
      vecs[4] = '{4'b0001, 8'h00, 2'd0};
      vecs[5] = '{4'b1000, 8'hFF, 2'd3};

      // Reset values
      reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack",         32'(ack),         32'd0);
      chk("rst_grant_id",    32'(grant_id),    32'd0);
      chk("rst_tx_start",    32'(tx_start),    32'd0);
      chk("rst_tx_data",     32'(tx_data),     32'd0);
      chk("rst_arb_busy",    32'(arb_busy),    32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;

      // Single request on slot 2; tx_busy held high 10 cycles
      @(negedge clk);
      drive_one(4'b0100, 2, 8'hA5);
      push_exp(2'd2, 8'hA5);
      @(negedge clk);                   // grant cycle done, now in START
      chk("t1_tx_start", 32'(tx_start), 32'd1);
      check_grant();
      chk("t1_arb_busy_start", 32'(arb_busy), 32'd1);
      req     = '0;
      tx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t1_arb_busy_hold", 32'(arb_busy), 32'd1);
         chk("t1_no_restart",    32'(tx_start), 32'd0);
      end
      tx_busy = 1'b0;
      @(negedge clk);
      chk("t1_idle_after_fall", 32'(arb_busy), 32'd0);

      // Table of single-requester transactions
      for (int v = 0; v < 6; v++) begin
         drive_one(vecs[v].req, int'(vecs[v].exp_id), vecs[v].data);
         push_exp(vecs[v].exp_id, vecs[v].data);
         run_frames(1, 3, 1'b1, 40);
      end

      // tx_busy high in IDLE blocks the grant
      tx_busy = 1'b1;
      drive_one(4'b0001, 0, 8'h5A);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("busy_idle_no_start", 32'(tx_start), 32'd0);
         chk("busy_idle_no_ack",   32'(ack),      32'd0);
      end
      tx_busy = 1'b0;
      push_exp(2'd0, 8'h5A);
      run_frames(1, 3, 1'b1, 40);

      // req_data change during START does not disturb tx_data
      drive_one(4'b0001, 0, 8'h55);
      push_exp(2'd0, 8'h55);
      @(negedge clk);
      check_grant();
      req_data[7:0] = 8'hAA;
      req     = '0;
      tx_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_tx_data", 32'(tx_data), 32'h55);
      end
      tx_busy = 1'b0;
      @(negedge clk);
      chk("hold_idle",        32'(arb_busy), 32'd0);
      chk("hold_tx_data_end", 32'(tx_data),  32'h55);

      // All requesters pending; pointer restarts from reset value
      do_reset();
      req_data = {8'h40, 8'h30, 8'h20, 8'h10};
      req      = 4'b1111;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 5; i++) push_exp(2'd0, 8'h10);
`else
      for (int i = 0; i < 5; i++) push_exp(2'(i % 4), 8'(8'h10 * ((i % 4) + 1)));
`endif
      run_frames(5, 5, 1'b0, 200);

      // tx_busy never rises -> timeout after BUSY_WAIT_MAX WAIT_BUSY cycles
      drive_one(4'b0001, 0, 8'h33);
      push_exp(2'd0, 8'h33);
      @(negedge clk);
      check_grant();
      req = '0;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (timeout_err) begin
            k = i;
            break;
         end
         chk("to_arb_busy_wait", 32'(arb_busy), 32'd1);
      end
      // START negedge, then 8 WAIT_BUSY cycles, flag visible on the next one
      chk("to_delay",       32'(k),           32'd9);
      chk("to_idle",        32'(arb_busy),    32'd0);
      chk("to_flag",        32'(timeout_err), 32'd1);
      drive_one(4'b0010, 1, 8'h44);
      push_exp(2'd1, 8'h44);
      run_frames(1, 3, 1'b1, 40);
      chk("to_sticky", 32'(timeout_err), 32'd1);

      // Asynchronous reset during WAIT_DONE
      drive_one(4'b0010, 1, 8'h66);
      push_exp(2'd1, 8'h66);
      @(negedge clk);
      check_grant();
      req     = '0;
      tx_busy = 1'b1;
      repeat (2) @(negedge clk);
      chk("mf_in_frame", 32'(arb_busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mf_tx_start",    32'(tx_start),    32'd0);
      chk("mf_ack",         32'(ack),         32'd0);
      chk("mf_tx_data",     32'(tx_data),     32'd0);
      chk("mf_arb_busy",    32'(arb_busy),    32'd0);
      chk("mf_timeout_err", 32'(timeout_err), 32'd0);
      chk("mf_grant_id",    32'(grant_id),    32'd0);
      @(negedge clk);
      reset   = 1'b0;
      tx_busy = 1'b0;
      drive_one(4'b1000, 3, 8'h99);
      push_exp(2'd3, 8'h99);
      run_frames(1, 3, 1'b1, 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
